// File: rtl/riscv_hwloop_unit.sv
// riscv_hwloop_unit: RI5CY hardware-loop unit. It holds the loop registers,
// detects loop ends, resolves nesting priority and tracks in-flight decrements.
// Optional feature macro: RISCV_HWLP_PENDING_EN enables speculative decrement
// tracking. When it is undefined, a hit decrements the counter directly and
// commit/flush are ignored.
// N_LOOPS must be at least 2 so that the index ports have a nonzero width.
module riscv_hwloop_unit #(
    parameter int unsigned N_LOOPS  = 2,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PEND_MAX = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [1:0]                    wr_sel_i,
    input  logic [$clog2(N_LOOPS)-1:0]    wr_idx_i,
    input  logic [31:0]                   wr_data_i,
    input  logic                          pc_valid_i,
    input  logic [31:0]                   current_pc_i,
    input  logic                          commit_i,
    input  logic [$clog2(N_LOOPS)-1:0]    commit_idx_i,
    input  logic                          flush_i,
    output logic                          jump_o,
    output logic [31:0]                   targ_addr_o,
    output logic                          stall_o,
    output logic [N_LOOPS-1:0][CNT_W-1:0] cnt_o
);
    localparam int unsigned IDX_W = $clog2(N_LOOPS);

    logic [31:0]      r_start [N_LOOPS];
    logic [31:0]      r_end   [N_LOOPS];
    logic [CNT_W-1:0] r_cnt   [N_LOOPS];

    logic [CNT_W-1:0]   w_eff [N_LOOPS];
    logic [N_LOOPS-1:0] w_match;
    logic               w_hit;
    logic [IDX_W-1:0]   w_sel;
    logic               w_issue;
    logic [N_LOOPS-1:0] w_wr_start;
    logic [N_LOOPS-1:0] w_wr_end;
    logic [N_LOOPS-1:0] w_wr_cnt;
    logic [N_LOOPS-1:0] w_inc;

`ifdef RISCV_HWLP_PENDING_EN
    localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);
    logic [PEND_W-1:0]  r_pend [N_LOOPS];
    logic               w_full;
    logic [N_LOOPS-1:0] w_commit;
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{commit_i, commit_idx_i, flush_i, PEND_MAX[0]};
`endif

    // Effective count (committed minus in-flight) and end-address match per loop
    always_comb begin
        for (int i = 0; i < N_LOOPS; i++) begin
`ifdef RISCV_HWLP_PENDING_EN
            w_eff[i] = r_cnt[i] - CNT_W'(r_pend[i]);
`else
            w_eff[i] = r_cnt[i];
`endif
            w_match[i] = pc_valid_i && (current_pc_i == r_end[i]) && (w_eff[i] != '0);
        end
    end

    // Innermost-first selection and redirect/stall outputs
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            if (w_match[i] && !w_hit) begin
                w_hit = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
`ifdef RISCV_HWLP_PENDING_EN
        w_full  = (r_pend[w_sel] == PEND_W'(PEND_MAX));
        stall_o = w_hit && w_full;
        jump_o  = w_hit && !w_full && (w_eff[w_sel] >= CNT_W'(2));
        // a flushed hit still drives the outputs but leaves no trace in pend
        w_issue = w_hit && !w_full && !flush_i;
`else
        stall_o = 1'b0;
        jump_o  = w_hit && (w_eff[w_sel] >= CNT_W'(2));
        w_issue = w_hit;
`endif
        targ_addr_o = jump_o ? r_start[w_sel] : 32'h0;
    end

    // Per-loop decode of register writes, hit increments and commits
    always_comb begin
        for (int i = 0; i < N_LOOPS; i++) begin
            w_wr_start[i] = wr_en_i && (wr_sel_i == 2'b00) && (wr_idx_i == IDX_W'(i));
            w_wr_end[i]   = wr_en_i && (wr_sel_i == 2'b01) && (wr_idx_i == IDX_W'(i));
            w_wr_cnt[i]   = wr_en_i && (wr_sel_i == 2'b10) && (wr_idx_i == IDX_W'(i));
            w_inc[i]      = w_issue && (w_sel == IDX_W'(i));
`ifdef RISCV_HWLP_PENDING_EN
            w_commit[i]   = commit_i && (commit_idx_i == IDX_W'(i));
`endif
        end
    end

    // Loop register state; a count write beats commit, and commit beats a hit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LOOPS; i++) begin
                r_start[i] <= '0;
                r_end[i]   <= '0;
                r_cnt[i]   <= '0;
`ifdef RISCV_HWLP_PENDING_EN
                r_pend[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < N_LOOPS; i++) begin
                if (w_wr_start[i]) r_start[i] <= wr_data_i;
                if (w_wr_end[i])   r_end[i]   <= wr_data_i;
`ifdef RISCV_HWLP_PENDING_EN
                if (w_wr_cnt[i]) begin
                    r_cnt[i]  <= wr_data_i[CNT_W-1:0];
                    r_pend[i] <= '0;
                end else begin
                    if (w_commit[i] && (r_cnt[i] != '0))
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    if (flush_i)
                        r_pend[i] <= '0;
                    else if (w_commit[i] && !w_inc[i] && (r_pend[i] != '0))
                        r_pend[i] <= r_pend[i] - PEND_W'(1);
                    else if (w_inc[i] && !w_commit[i])
                        r_pend[i] <= r_pend[i] + PEND_W'(1);
                end
`else
                if (w_wr_cnt[i])
                    r_cnt[i] <= wr_data_i[CNT_W-1:0];
                else if (w_inc[i])
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
`endif
            end
        end
    end

    // Architectural counters are the committed registers
    always_comb begin
        for (int i = 0; i < N_LOOPS; i++) cnt_o[i] = r_cnt[i];
    end

endmodule

// File: tb/tb_riscv_hwloop_unit.sv
// Self-checking bench for riscv_hwloop_unit (default parameters). Vectors hold
// one cycle of stimulus, the expected same-cycle outputs and the counters
// expected after the edge; the counters go through a scoreboard queue.
module tb_riscv_hwloop_unit;
    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en_i;
    logic [1:0]       wr_sel_i;
    logic             wr_idx_i;
    logic [31:0]      wr_data_i;
    logic             pc_valid_i;
    logic [31:0]      current_pc_i;
    logic             commit_i;
    logic             commit_idx_i;
    logic             flush_i;
    logic             jump_o;
    logic [31:0]      targ_addr_o;
    logic             stall_o;
    logic [1:0][31:0] cnt_o;

    riscv_hwloop_unit dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
        .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i), .pc_valid_i(pc_valid_i),
        .current_pc_i(current_pc_i), .commit_i(commit_i), .commit_idx_i(commit_idx_i),
        .flush_i(flush_i), .jump_o(jump_o), .targ_addr_o(targ_addr_o),
        .stall_o(stall_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wen;
        logic [1:0]  sel;
        logic        idx;
        logic [31:0] data;
        logic        pcv;
        logic [31:0] pc;
        logic        cm;
        logic        cidx;
        logic        fl;
        logic        jump;
        logic [31:0] targ;
        logic        stall;
        logic [31:0] c0;
        logic [31:0] c1;
    } vec_t;

    typedef struct {
        logic [31:0] c0;
        logic [31:0] c1;
        int          vi;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic we, input logic [1:0] s,
                                input logic ix, input logic [31:0] d, input logic pv,
                                input logic [31:0] pc, input logic cm, input logic ci,
                                input logic fl, input logic j, input logic [31:0] t,
                                input logic st, input logic [31:0] c0, input logic [31:0] c1);
        vec_t v;
        v.rst = r;  v.wen = we; v.sel = s;  v.idx = ix; v.data = d;
        v.pcv = pv; v.pc = pc;  v.cm = cm;  v.cidx = ci; v.fl = fl;
        v.jump = j; v.targ = t; v.stall = st; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    function automatic vec_t fw(input logic [1:0] s, input logic ix, input logic [31:0] d,
                                input logic [31:0] c0, input logic [31:0] c1);
        return mk(0, 1, s, ix, d, 0, 0, 0, 0, 0, 0, 0, 0, c0, c1);
    endfunction

    function automatic vec_t fh(input logic [31:0] pc, input logic j, input logic [31:0] t,
                                input logic st, input logic [31:0] c0, input logic [31:0] c1);
        return mk(0, 0, 0, 0, 0, 1, pc, 0, 0, 0, j, t, st, c0, c1);
    endfunction

    task automatic check(input string nm, input int vi, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", nm, vi, act, exp);
        end
    endtask

    // Drive one cycle, check same-cycle outputs, then the post-edge counters
    task automatic apply(input vec_t v);
        sb_t e;
        @(negedge clk);
        rst = v.rst; wr_en_i = v.wen; wr_sel_i = v.sel; wr_idx_i = v.idx;
        wr_data_i = v.data; pc_valid_i = v.pcv; current_pc_i = v.pc;
        commit_i = v.cm; commit_idx_i = v.cidx; flush_i = v.fl;
        #1;
        check("jump", n_vec, 32'(jump_o), 32'(v.jump));
        check("targ", n_vec, targ_addr_o, v.targ);
        check("stall", n_vec, 32'(stall_o), 32'(v.stall));
        e.c0 = v.c0; e.c1 = v.c1; e.vi = n_vec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", n_vec, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("cnt0", e.vi, cnt_o[0], e.c0);
            check("cnt1", e.vi, cnt_o[1], e.c1);
        end
        n_vec++;
    endtask

    initial begin
        int n;
        rst = 1'b1; wr_en_i = 0; wr_sel_i = 0; wr_idx_i = 0; wr_data_i = 0;
        pc_valid_i = 0; current_pc_i = 0; commit_i = 0; commit_idx_i = 0; flush_i = 0;
        repeat (2) @(posedge clk);

`ifdef RISCV_HWLP_PENDING_EN
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(fw(0, 0, 32'h100, 0, 0));
        vecs.push_back(fw(1, 0, 32'h110, 0, 0));
        vecs.push_back(fw(2, 0, 3, 3, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 3, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h110, 1, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h110, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(fw(2, 0, 8, 8, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 8, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 8, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 8, 0));
        vecs.push_back(fh(32'h110, 0, 0, 1, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h110, 0, 0, 1, 0, 0, 1, 8, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h110, 0, 0, 1, 1, 32'h100, 0, 8, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 7, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 7, 0));
        vecs.push_back(mk(0, 1, 2, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 2, 0));
        vecs.push_back(fh(32'h110, 0, 0, 0, 2, 0));
        vecs.push_back(fh(32'h110, 0, 0, 0, 2, 0));
        vecs.push_back(fw(0, 1, 32'h200, 2, 0));
        vecs.push_back(fw(1, 1, 32'h110, 2, 0));
        vecs.push_back(mk(0, 1, 2, 1, 7, 0, 0, 1, 1, 0, 0, 0, 0, 2, 7));
        vecs.push_back(fh(32'h110, 1, 32'h200, 0, 2, 7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h110, 0, 0, 0, 1, 32'h200, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(fh(32'h110, 0, 0, 0, 0, 0));
`else
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(fw(0, 0, 32'h100, 0, 0));
        vecs.push_back(fw(1, 0, 32'h110, 0, 0));
        vecs.push_back(fw(2, 0, 3, 3, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 2, 0));
        vecs.push_back(fh(32'h110, 1, 32'h100, 0, 1, 0));
        vecs.push_back(fh(32'h110, 0, 0, 0, 0, 0));
        vecs.push_back(fh(32'h110, 0, 0, 0, 0, 0));
        vecs.push_back(fw(0, 0, 32'h180, 0, 0));
        vecs.push_back(fw(1, 0, 32'h120, 0, 0));
        vecs.push_back(fw(0, 1, 32'h200, 0, 0));
        vecs.push_back(fw(1, 1, 32'h120, 0, 0));
        vecs.push_back(fw(2, 0, 2, 2, 0));
        vecs.push_back(fw(2, 1, 5, 2, 5));
        vecs.push_back(fh(32'h120, 1, 32'h180, 0, 1, 5));
        vecs.push_back(fh(32'h120, 0, 0, 0, 0, 5));
        vecs.push_back(fh(32'h120, 1, 32'h200, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h120, 0, 0, 1, 1, 32'h200, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3));
        vecs.push_back(fw(3, 1, 9, 0, 3));
        vecs.push_back(mk(0, 1, 2, 1, 7, 1, 32'h120, 0, 0, 0, 1, 32'h200, 0, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h120, 0, 0, 0, 0, 0, 0, 0, 7));
        vecs.push_back(fh(32'h121, 0, 0, 0, 0, 7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h120, 0, 0, 0, 1, 32'h200, 0, 0, 0));
        vecs.push_back(fh(32'h120, 0, 0, 0, 0, 0));
`endif
        foreach (vecs[k]) apply(vecs[k]);

        // Full loops of random length, each hit committed in the same cycle so
        // both builds decrement the architectural counter once per hit
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(2, 6));
            apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            apply(fw(0, 0, 32'h300, 0, 0));
            apply(fw(1, 0, 32'h310, 0, 0));
            apply(fw(2, 0, 32'(n), 32'(n), 0));
            for (int k = n; k >= 1; k--)
                apply(mk(0, 0, 0, 0, 0, 1, 32'h310, 1, 0, 0, (k >= 2),
                         (k >= 2) ? 32'h300 : 32'h0, 0, 32'(k - 1), 0));
            apply(fh(32'h310, 0, 0, 0, 0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
